// File: rtl/fetch_stage_pkg.sv
// Shared processor definitions for the fetch stage: opcodes, FSM encoding and
// the IF/ID bundle. The bundle PC field width (PC_W) fixes the fetch ADDR_W.
package fetch_stage_pkg;

    localparam int         PC_W    = 16;
    localparam logic [4:0] OPC_LDM = 5'b01101;
    localparam logic [4:0] OPC_HLT = 5'b00001;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_IMM   = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [15:0]     instr;
        logic [15:0]     imm;
        logic            ldm;
        logic [PC_W-1:0] pc;
        logic            valid;
    } if_id_t;

    function automatic logic [4:0] opcode_of(input logic [15:0] word);
        return word[15:11];
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with redirect > stall > increment priority.
// Increment wraps modulo 2^ADDR_W.
module pc_reg #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (!stall_i && inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, two-word LDM assembly into the IF/ID register, stall and
// redirect handling. Define FETCH_HALT_EN to stop fetching after an HLT word.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W     = PC_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [4:0]        LDM_OPCODE = OPC_LDM,
    parameter logic [4:0]        HLT_OPCODE = OPC_HLT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       if_id_instr,
    output logic [15:0]       if_id_imm,
    output logic              if_id_ldm,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    if_id_t            if_id_q, if_id_d;
    logic [15:0]       hold_q, hold_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;
    logic              is_ldm;
    logic              is_hlt;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .inc_i         (pc_inc),
        .pc_o          (pc)
    );

    assign is_ldm = (opcode_of(imem_rdata) == LDM_OPCODE);

`ifdef FETCH_HALT_EN
    assign is_hlt = (opcode_of(imem_rdata) == HLT_OPCODE);
    assign halted = (state_q == ST_HALT);
`else
    logic unused_hlt_opcode;
    assign unused_hlt_opcode = ^HLT_OPCODE;
    assign is_hlt = 1'b0;
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = ST_FETCH;
        end else if (!stall) begin
            case (state_q)
                ST_FETCH: begin
                    if (is_ldm) begin
                        state_d = ST_IMM;
                    end else if (is_hlt) begin
                        state_d = ST_HALT;
                    end
                end
                ST_IMM:  state_d = ST_FETCH;
                default: state_d = state_q;
            endcase
        end
    end

    // The word fetched in IMM is the immediate; it never goes through opcode decode.
    always_comb begin
        if_id_d   = if_id_q;
        hold_d    = hold_q;
        hold_pc_d = hold_pc_q;
        pc_inc    = 1'b0;
        if (redirect) begin
            if_id_d.valid = 1'b0;
            hold_d        = '0;
        end else if (!stall) begin
            case (state_q)
                ST_FETCH: begin
                    if (is_ldm) begin
                        hold_d        = imem_rdata;
                        hold_pc_d     = pc;
                        if_id_d.valid = 1'b0;
                        pc_inc        = 1'b1;
                    end else begin
                        if_id_d.instr = imem_rdata;
                        if_id_d.imm   = imem_rdata;
                        if_id_d.ldm   = 1'b0;
                        if_id_d.pc    = pc;
                        if_id_d.valid = 1'b1;
                        pc_inc        = !is_hlt;
                    end
                end
                ST_IMM: begin
                    if_id_d.instr = hold_q;
                    if_id_d.imm   = imem_rdata;
                    if_id_d.ldm   = 1'b1;
                    if_id_d.pc    = hold_pc_q;
                    if_id_d.valid = 1'b1;
                    pc_inc        = 1'b1;
                end
                default: if_id_d.valid = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q   <= '0;
            hold_q    <= '0;
            hold_pc_q <= '0;
        end else begin
            if_id_q   <= if_id_d;
            hold_q    <= hold_d;
            hold_pc_q <= hold_pc_d;
        end
    end

    assign imem_addr   = pc;
    assign if_id_instr = if_id_q.instr;
    assign if_id_imm   = if_id_q.imm;
    assign if_id_ldm   = if_id_q.ldm;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_valid = if_id_q.valid;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage feeding the decode stage, the `immediate_control` path and the register file. It owns the PC, reads 16-bit words from instruction memory, and assembles two-word LDM instructions: the opcode word plus the following immediate word. It delivers one complete instruction per valid cycle into the IF/ID register, with the `ldm` flag that selects the raw immediate word downstream. It also handles stall, redirect (branch/jump/flush) and, optionally, halt.

## Interface
Parameters:
- `ADDR_W`, 16: PC / instruction address width.
- `RESET_PC`, 0: PC value after reset.
- `LDM_OPCODE`, 5'b01101: `instr[15:11]` value marking a two-word LDM.
- `HLT_OPCODE`, 5'b00001: `instr[15:11]` value of HLT (used only with `FETCH_HALT_EN`).

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `imem_addr`, out, ADDR_W: word address, equal to the current PC.
- `imem_rdata`, in, 16: word at `imem_addr`, combinational (same-cycle) read.
- `stall`, in, 1: hold the whole stage, including the PC, IF/ID and FSM.
- `redirect`, in, 1: load the PC from `redirect_pc` and squash in-flight fetch state.
- `redirect_pc`, in, ADDR_W: redirect target.
- `if_id_instr`, out, 16: instruction word; for LDM this is the opcode word.
- `if_id_imm`, out, 16: immediate word for LDM, otherwise a copy of `if_id_instr`. Drives `immediate_control`'s `Inp`.
- `if_id_ldm`, out, 1: registered instruction is LDM. Drives `immediate_control`'s `LDM`.
- `if_id_pc`, out, ADDR_W: address of the instruction's first word.
- `if_id_valid`, out, 1: IF/ID contents are a real instruction; when 0 the stage is issuing a bubble.
- `halted`, out, 1: fetch halted (constant 0 without `FETCH_HALT_EN`).

## Operation
- FSM states:
  - FETCH: normal fetch.
  - IMM: fetching the second word of an LDM.
  - HALT: fetch stopped (exists only with `FETCH_HALT_EN`).
- The FSM resets to FETCH.
- Reset values: PC = `RESET_PC`; `if_id_instr` = `if_id_imm` = 0; `if_id_pc` = 0; `if_id_ldm` = 0; `if_id_valid` = 0; `halted` = 0; hold register = 0.
- Event priority at each edge: redirect > stall > normal.
- Redirect:
  - PC ← `redirect_pc`; FSM → FETCH.
  - `if_id_valid` ← 0.
  - The held LDM word is discarded.
  - `halted` clears.
- Stall without redirect: every register holds, and `imem_addr` stays stable.
- FETCH with a word whose `[15:11]` equals `LDM_OPCODE`:
  - Hold register ← word; held PC ← PC.
  - PC ← PC+1; FSM → IMM.
  - `if_id_valid` ← 0 (one bubble).
- FETCH with any other word:
  - `if_id_instr` ← word; `if_id_imm` ← word.
  - `if_id_ldm` ← 0; `if_id_pc` ← PC; `if_id_valid` ← 1.
  - PC ← PC+1.
- IMM:
  - `if_id_instr` ← hold register; `if_id_imm` ← `imem_rdata`.
  - `if_id_ldm` ← 1; `if_id_pc` ← held PC; `if_id_valid` ← 1.
  - PC ← PC+1; FSM → FETCH.
  - The second word is never decoded as an opcode, even if its top bits match `LDM_OPCODE`.
- PC arithmetic is modulo 2^ADDR_W: the last address wraps to 0. An LDM whose opcode word sits at the last address takes its immediate from address 0.
- When `if_id_valid` = 0, the payload fields keep their previous values; downstream uses `if_id_valid` only.

## Timing
- Fetch-to-IF/ID latency is 1 cycle.
- Throughput:
  - Non-LDM: one instruction per cycle.
  - LDM: one instruction per 2 cycles, with exactly one bubble cycle ahead of the valid one.
- Stall during IMM keeps the hold register. The LDM completes on the first unstalled edge.
- Redirect during IMM squashes the half-fetched LDM; no valid output is produced for it.
- Deasserting `rst_n` mid-operation immediately forces all reset values (asynchronous). The first fetch after release is at `RESET_PC`.

## Configuration
- `FETCH_HALT_EN` defined:
  - In FETCH, a word with `[15:11]` = `HLT_OPCODE` is registered as a valid instruction.
  - The PC is not incremented, and the FSM → HALT.
  - In HALT: `if_id_valid` = 0, `halted` = 1, PC frozen.
  - Only a redirect or a reset leaves HALT.
- `FETCH_HALT_EN` undefined: HLT is an ordinary word, there is no HALT state, and `halted` is tied to 0.

## Structure
- Shared processor package holds:
  - The opcode constants `LDM_OPCODE` and `HLT_OPCODE`.
  - The FSM state encoding (FETCH=2'd0, IMM=2'd1, HALT=2'd2).
  - The IF/ID bundle type: instr, imm, ldm, pc, valid.
- One natural sub-module, `pc_reg`: the PC register with redirect, stall and increment muxing. Everything else stays in `fetch_stage`.

## Test plan
- Reset with `RESET_PC`=0 and imem[0..2] = 16'h1234, 16'h2000, 16'h3001 → valid outputs 1234, 2000, 3001 on consecutive cycles, `if_id_pc` = 0, 1, 2, `if_id_ldm` = 0.
- imem[4] = 16'h6805 (LDM), imem[5] = 16'hBEEF → one bubble, then `if_id_instr`=6805, `if_id_imm`=BEEF, `if_id_ldm`=1, `if_id_pc`=4; the next fetch is at 6.
- Same LDM with `stall` high for 3 cycles while in IMM → output is unchanged after the stall and the PC never skips.
- Redirect to 16'h0040 while in IMM → `if_id_valid`=0 for that LDM and the next valid instruction has `if_id_pc`=0x40.
- PC at 16'hFFFF holding an LDM, imem[0]=16'h00AA → `if_id_imm`=00AA and the PC continues at 1.
- With `FETCH_HALT_EN`, imem[8]=16'h0800 → HLT is registered valid, `halted`=1 from the next cycle, and the PC holds at 8 until a redirect to 0x10 resumes fetch.
